pipe_fwd_unit: RTL and testbench

PIPE_FWD_UNIT -- requirements
Module: pipe_fwd_unit

---
 rtl/pipe_fwd_pkg.sv | 24 ++
 rtl/fwd_port_sel.sv | 49 ++++
 rtl/pipe_fwd_unit.sv | 138 +++++++++++++
 tb/tb_pipe_fwd_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fwd_pkg.sv
// Shared types and default sizes for the pipeline forwarding unit.
// History entries use maximum-width fields; users slice to DATA_W/ADDR_W.
package pipe_fwd_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 5;
  localparam int DEPTH_DEF      = 2;
  localparam int NUM_RD_DEF     = 2;
  localparam int FWD_MAX_DATA_W = 32;
  localparam int FWD_MAX_ADDR_W = 8;

  typedef struct packed {
    logic                      valid;
    logic                      late;
    logic [FWD_MAX_ADDR_W-1:0] addr;
    logic [FWD_MAX_DATA_W-1:0] data;
  } fwd_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port operand select: youngest matching producer wins, else RF data.
// Combinational; flags an EX hazard (late producer, or any EX match without PIPE_FWD_EX_BYPASS_EN).
module fwd_port_sel #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                    i_rd_en,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  input  logic [DATA_W-1:0]       i_rf_data,
  input  logic                    i_ex_live,
  input  logic                    i_ex_late,
  input  logic [ADDR_W-1:0]       i_ex_addr,
  input  logic [DATA_W-1:0]       i_ex_data,
  input  logic [DEPTH-1:0]        i_hist_vld,
  input  logic [DEPTH*ADDR_W-1:0] i_hist_addr,
  input  logic [DEPTH*DATA_W-1:0] i_hist_data,
  output logic [DATA_W-1:0]       o_fwd_data,
  output logic                    o_hazard
);

  logic w_ex_match;

  assign w_ex_match = i_ex_live && (i_ex_addr == i_rd_addr);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_fwd_data = i_rf_data;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_hist_vld[k] && (i_hist_addr[k*ADDR_W +: ADDR_W] == i_rd_addr)) begin
        o_fwd_data = i_hist_data[k*DATA_W +: DATA_W];
      end
    end
`ifdef PIPE_FWD_EX_BYPASS_EN
    if (w_ex_match && !i_ex_late) begin
      o_fwd_data = i_ex_data;
    end
`endif
  end

`ifdef PIPE_FWD_EX_BYPASS_EN
  assign o_hazard = i_rd_en && w_ex_match && i_ex_late;
`else
  logic w_unused_ex;
  assign w_unused_ex = ^{i_ex_late, i_ex_data};
  assign o_hazard    = i_rd_en && w_ex_match;
`endif

endmodule

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding with one-cycle load-use stall; EX bypass under PIPE_FWD_EX_BYPASS_EN.
// Forwarding is combinational; hold freezes history, FSM and stall counter.
module pipe_fwd_unit
  import pipe_fwd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_wr_en,
  input  logic [ADDR_W-1:0]        ex_wr_addr,
  input  logic [DATA_W-1:0]        ex_result,
  input  logic                     ex_late,
  input  logic [DATA_W-1:0]        wb_late_data,
  input  logic                     flush,
  input  logic                     hold,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rd_rf_data,
  output logic [NUM_RD*DATA_W-1:0] rd_fwd_data,
  output logic                     stall,
  output logic                     rf_wr_en,
  output logic [ADDR_W-1:0]        rf_wr_addr,
  output logic [DATA_W-1:0]        rf_wr_data,
  output logic [15:0]              stall_cnt
);

  fwd_state_e              r_state;
  fwd_state_e              w_state_nxt;
  logic                    w_bubble;
  fwd_entry_t              r_hist [DEPTH];
  logic [DATA_W-1:0]       w_res_data [DEPTH];
  logic [DEPTH-1:0]        w_hist_vld;
  logic [DEPTH*ADDR_W-1:0] w_hist_addr;
  logic [DEPTH*DATA_W-1:0] w_hist_data;
  logic [NUM_RD-1:0]       w_hazard;
  logic                    w_stall;
  logic                    w_ex_live;
  logic                    w_unused_hi;
  logic [15:0]             r_stall_cnt;

  assign w_ex_live = ex_wr_en & ~flush;
  assign w_stall   = |w_hazard;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // The EX slot seen while STALLED is the inserted bubble and never enters history.
  always_comb begin
    w_state_nxt = r_state;
    w_bubble    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_stall && !hold) w_state_nxt = STALLED;
      end
      STALLED: begin
        w_bubble = 1'b1;
        if (!hold) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_unused_hi = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_res_data[k] = r_hist[k].late ? wb_late_data : r_hist[k].data[DATA_W-1:0];
      w_hist_vld[k] = r_hist[k].valid;
      w_hist_addr[k*ADDR_W +: ADDR_W] = r_hist[k].addr[ADDR_W-1:0];
      w_hist_data[k*DATA_W +: DATA_W] = w_res_data[k];
      w_unused_hi = w_unused_hi ^ (^(r_hist[k].data >> DATA_W)) ^ (^(r_hist[k].addr >> ADDR_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_hist[k] <= '0;
    end else if (!hold) begin
      r_hist[0].valid <= w_ex_live & ~w_bubble;
      r_hist[0].late  <= ex_late;
      r_hist[0].addr  <= FWD_MAX_ADDR_W'(ex_wr_addr);
      r_hist[0].data  <= FWD_MAX_DATA_W'(ex_result);
      // Late data is captured from wb_late_data as it leaves entry 0.
      for (int k = 1; k < DEPTH; k++) begin
        r_hist[k].valid <= r_hist[k-1].valid;
        r_hist[k].late  <= 1'b0;
        r_hist[k].addr  <= r_hist[k-1].addr;
        r_hist[k].data  <= FWD_MAX_DATA_W'(w_res_data[k-1]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!hold && w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_sel (
      .i_rd_en     (rd_en[p]),
      .i_rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .i_rf_data   (rd_rf_data[p*DATA_W +: DATA_W]),
      .i_ex_live   (w_ex_live),
      .i_ex_late   (ex_late),
      .i_ex_addr   (ex_wr_addr),
      .i_ex_data   (ex_result),
      .i_hist_vld  (w_hist_vld),
      .i_hist_addr (w_hist_addr),
      .i_hist_data (w_hist_data),
      .o_fwd_data  (rd_fwd_data[p*DATA_W +: DATA_W]),
      .o_hazard    (w_hazard[p])
    );
  end

  assign stall      = w_stall;
  assign stall_cnt  = r_stall_cnt;
  assign rf_wr_en   = r_hist[0].valid & ~hold;
  assign rf_wr_addr = r_hist[0].addr[ADDR_W-1:0];
  assign rf_wr_data = w_res_data[0];

  // A late producer resolves after one bubble; a hazard here means the bubble was not inserted.
  a_no_hazard_when_stalled: assert property (
    @(posedge clk) disable iff (rst) (r_state == STALLED) |-> !w_stall
  );

endmodule

// File: tb/tb_pipe_fwd_unit.sv
// Scoreboarded bench for pipe_fwd_unit: directed scenarios then randomized traffic.
module tb_pipe_fwd_unit;

  localparam int DW = 8, AW = 5, DEPTH = 2, NRD = 2;
`ifdef PIPE_FWD_EX_BYPASS_EN
  localparam int CNT1 = 1;
`else
  localparam int CNT1 = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, ex_wr_en = 1'b0, ex_late = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [AW-1:0] ex_wr_addr = '0;
  logic [DW-1:0] ex_result = '0, wb_late_data = '0;
  logic [NRD-1:0] rd_en = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_rf_data = '0;
  logic [NRD*DW-1:0] rd_fwd_data;
  logic stall, rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [15:0] stall_cnt;

  pipe_fwd_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_RD(NRD)) dut (
    .clk(clk), .rst(rst), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .ex_late(ex_late), .wb_late_data(wb_late_data), .flush(flush), .hold(hold), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_rf_data(rd_rf_data), .rd_fwd_data(rd_fwd_data), .stall(stall),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit            v;
    bit            late;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ment_t;

  typedef struct {
    bit                skip;
    logic [NRD*DW-1:0] fwd;
    bit                stl;
    bit                wen;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    int                cnt;
  } exp_t;

  ment_t mh[$];       // index 0 = most recent write (WB stage)
  exp_t  exp_q[$];
  bit    m_known = 0, m_stalled = 0;
  int    m_cnt = 0;
  int    errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, queues the expected outputs, then advances the model past the edge.
  task automatic apply(input bit r, input bit hl, input bit fl, input bit we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wr, input bit lt,
                       input logic [DW-1:0] wbl, input logic [NRD-1:0] re,
                       input logic [NRD*AW-1:0] ra, input logic [NRD*DW-1:0] rfd);
    exp_t  e;
    ment_t n;
    bit    live;
    @(posedge clk);
    #1;
    rst = r; hold = hl; flush = fl; ex_wr_en = we; ex_wr_addr = wa; ex_result = wr;
    ex_late = lt; wb_late_data = wbl; rd_en = re; rd_addr = ra; rd_rf_data = rfd;
    live   = we && !fl;
    e.skip = !m_known;
    e.stl  = 0;
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] f;
      bit            found;
      a = ra[p*AW +: AW];
      f = rfd[p*DW +: DW];
      found = 0;
`ifdef PIPE_FWD_EX_BYPASS_EN
      if (live && !lt && wa == a) begin f = wr; found = 1; end
      if (re[p] && live && wa == a && lt) e.stl = 1;
`else
      if (re[p] && live && wa == a) e.stl = 1;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && mh[i].v && mh[i].a == a) begin
          f = mh[i].late ? wbl : mh[i].d;
          found = 1;
        end
      end
      e.fwd[p*DW +: DW] = f;
    end
    e.wen = mh[0].v && !hl;
    e.wa  = mh[0].a;
    e.wd  = mh[0].late ? wbl : mh[0].d;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (r) begin
      foreach (mh[i]) mh[i].v = 0;
      m_stalled = 0;
      m_cnt     = 0;
      m_known   = 1;
    end else if (!hl) begin
      if (mh[0].late) begin mh[0].d = wbl; mh[0].late = 0; end
      n = '{v: live && !m_stalled, late: lt, a: wa, d: wr};
      mh.push_front(n);
      void'(mh.pop_back());
      if (e.stl && m_cnt < 65535) m_cnt++;
      m_stalled = e.stl;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!e.skip) begin
        chk("fwd_data", rd_fwd_data, e.fwd);
        chk("stall", stall, e.stl);
        chk("rf_wr_en", rf_wr_en, e.wen);
        if (e.wen) begin
          chk("rf_wr_addr", rf_wr_addr, e.wa);
          chk("rf_wr_data", rf_wr_data, e.wd);
        end
        chk("stall_cnt", stall_cnt, e.cnt);
      end
    end
  end

  localparam logic [15:0] RF = 16'hB1A2;

  initial begin : stim
    ment_t z;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] ra;
    bit r, hl, fl, we, lt;
    logic [AW-1:0] wa;
    z = '{v: 0, late: 0, a: '0, d: '0};
    for (int i = 0; i < DEPTH; i++) mh.push_back(z);

    // Reset, including reset while hold is asserted.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, RF);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, RF);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, RF);
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    chk("rst_fwd", rd_fwd_data, RF);
    chk("rst_cnt", stall_cnt, 0);

    // EX non-late r3 = 5A read in the same cycle.
    apply(0, 0, 0, 1, 5'd3, 8'h5A, 0, 8'h00, 2'b01, {5'd0, 5'd3}, RF);
    settle();
`ifdef PIPE_FWD_EX_BYPASS_EN
    chk("ex_bypass_data", rd_fwd_data[7:0], 8'h5A);
    chk("ex_bypass_stall", stall, 0);
`else
    chk("ex_nobypass_stall", stall, 1);
`endif
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, {5'd0, 5'd3}, RF);
    settle();
    chk("r3_fwd", rd_fwd_data[7:0], 8'h5A);
    chk("r3_stall", stall, 0);
    chk("r3_wr_en", rf_wr_en, 1);
    chk("r3_wr_data", rf_wr_data, 8'h5A);

    // Late r7, resolved from wb_late_data after one stall cycle.
    apply(0, 0, 0, 1, 5'd7, 8'h00, 1, 8'h00, 2'b10, {5'd7, 5'd0}, RF);
    settle();
    chk("late_stall", stall, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 8'hC3, 2'b10, {5'd7, 5'd0}, RF);
    settle();
    chk("late_fwd", rd_fwd_data[15:8], 8'hC3);
    chk("late_stall_clr", stall, 0);
    chk("late_cnt", stall_cnt, CNT1);
    chk("late_wr_data", rf_wr_data, 8'hC3);

    // Back-to-back r2 writes; both ports read r2, youngest wins.
    apply(0, 0, 0, 1, 5'd2, 8'h11, 0, 0, 2'b00, 0, RF);
    apply(0, 0, 0, 1, 5'd2, 8'h22, 0, 0, 2'b00, 0, RF);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, {5'd2, 5'd2}, RF);
    settle();
    chk("youngest_both", rd_fwd_data, 16'h2222);

    // Flushed write to r4 never commits or forwards.
    apply(0, 0, 1, 1, 5'd4, 8'hFF, 0, 0, 2'b00, 0, RF);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, {5'd0, 5'd4}, RF);
    settle();
    chk("flush_wr_en", rf_wr_en, 0);
    chk("flush_fwd", rd_fwd_data[7:0], 8'hA2);

    // Hold for three cycles with r5 in entry 0, then release.
    apply(0, 0, 0, 1, 5'd5, 8'h77, 0, 0, 2'b00, 0, RF);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, {5'd0, 5'd5}, RF);
      settle();
      chk("hold_wr_en", rf_wr_en, 0);
      chk("hold_fwd", rd_fwd_data[7:0], 8'h77);
      chk("hold_cnt", stall_cnt, CNT1);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, {5'd0, 5'd5}, RF);
    settle();
    chk("release_wr_en", rf_wr_en, 1);
    chk("release_wr_addr", rf_wr_addr, 5'd5);
    chk("release_wr_data", rf_wr_data, 8'h77);

    // Reset in the middle of a stall.
    apply(0, 0, 0, 1, 5'd6, 8'h00, 1, 0, 2'b01, {5'd0, 5'd6}, RF);
    settle();
    chk("pre_rst_stall", stall, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, RF);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, RF);
    settle();
    chk("midrst_stall", stall, 0);
    chk("midrst_wr_en", rf_wr_en, 0);
    chk("midrst_cnt", stall_cnt, 0);

    // EX non-late r1 match.
    apply(0, 0, 0, 1, 5'd1, 8'h3C, 0, 0, 2'b01, {5'd0, 5'd1}, RF);
    settle();
`ifdef PIPE_FWD_EX_BYPASS_EN
    chk("r1_stall", stall, 0);
    chk("r1_fwd", rd_fwd_data[7:0], 8'h3C);
`else
    chk("r1_stall", stall, 1);
`endif
    apply(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, {5'd0, 5'd1}, RF);
    settle();
    chk("r1_after", rd_fwd_data[7:0], 8'h3C);

    // Random traffic; a held decode never meets a new EX producer while stalled.
    re = '0;
    ra = '0;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      hl = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 1) == 1);
      lt = ($urandom_range(0, 2) == 0);
      wa = AW'($urandom_range(0, 3));
      if (!m_stalled) begin
        re = NRD'($urandom);
        ra = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      end else begin
        for (int p = 0; p < NRD; p++) if (re[p] && ra[p*AW +: AW] == wa) we = 0;
      end
      apply(r, hl, fl, we, wa, DW'($urandom), lt, DW'($urandom), re, ra, 16'($urandom));
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
